overflow_epoch_logger: RTL and testbench
========================================

// Module: overflow_epoch_logger
// PURPOSE
//   Downstream consumer of the 4-bit wrap counter. Tracks counter wrap events
//   (overflow pulses) as a wider epoch count. Logs each wrap, and each
//   software snapshot request, as a record {kind, epoch, count}.
//   Records are buffered in a small FIFO and drained over a valid/ready interface.
// PARAMETERS
//   CNT_W    4   width of upstream count
//   EPOCH_W  12  width of epoch (wrap) counter
//   DEPTH    4   FIFO entries; power of 2, >= 2
//   DROP_W   8   width of saturating drop counter
// PORTS
//   clk        in   1            single clock, all logic on posedge
//   reset_n    in   1            asynchronous, active-low reset
//   cnt_in     in   CNT_W        upstream count value, sampled on posedge
//   ovf_in     in   1            upstream wrap pulse, 1 cycle per wrap
//   snap_req   in   1            request a snapshot record (1-cycle pulse)
//   clear      in   1            synchronous clear: epoch, FIFO, drop_cnt
//   out_valid  out  1            head record available
//   out_ready  in   1            consumer accepts head when out_valid&&out_ready
//   out_data   out  1+EPOCH_W+CNT_W  {kind, epoch, count}; kind 1=OVF, 0=SNAP
//   fifo_full  out  1            FIFO holds DEPTH records
//   drop_cnt   out  DROP_W       records lost to full FIFO, saturating
//   epoch_wrap out  1            1-cycle pulse when epoch rolls over to 0
// BEHAVIOUR
// - Reset (reset_n=0, async) forces the following to 0:
//   epoch, rd/wr pointers, occupancy, drop_cnt, epoch_wrap, out_valid, fifo_full.
//   out_data is don't-care. Reset mid-operation discards all FIFO contents.
// - Priority, per posedge: clear > push/pop. While clear=1:
//   - epoch, occupancy and drop_cnt go to 0; epoch_wrap goes to 0.
//   - Inputs in the same cycle are ignored.
// - Epoch: on ovf_in=1, epoch <= epoch+1, modulo 2^EPOCH_W.
//   - On the all-ones -> 0 transition, epoch_wrap=1 for exactly the next cycle.
//   - Epoch increments even when the record is dropped.
// - Push generation (at most one push per cycle):
//   - ovf_in=1: push {1, epoch+1 (post-increment, wrapped), cnt_in}.
//   - snap_req=1, ovf_in=0: push {0, epoch, cnt_in}.
//   - Both high: one OVF record only; the snapshot is considered served.
// - Pop: occurs when out_valid && out_ready.
// - Push while full: accepted if a pop occurs in the same cycle; otherwise
//   the record is dropped and drop_cnt increments (holds at 2^DROP_W-1).
// - Simultaneous push+pop when not full or empty: occupancy unchanged.
// - Latency: a push at edge N makes out_valid=1 from edge N onward (visible
//   in cycle N+1); out_data is the head entry, read combinationally.
// - Handshake: while out_valid && !out_ready, out_data is held stable and
//   out_valid stays 1. out_valid = (occupancy != 0); fifo_full =
//   (occupancy == DEPTH).
// - Ordering: strict FIFO. Pointer widths: log2(DEPTH) bits plus 1 wrap bit.
// - No assumption on cnt_in/ovf_in relation beyond sampling; ovf_in held
//   high N cycles = N wrap events.
// STRUCTURE
// - Shared package ovf_log_pkg:
//   - localparams KIND_SNAP=1'b0, KIND_OVF=1'b1;
//   - record field offsets/width function REC_W = 1+EPOCH_W+CNT_W.
// - Sub-module epoch_rec_fifo (DEPTH x REC_W register-array sync FIFO).
//   - Inputs: push, pop, clear. Outputs: head, empty, full, occupancy.
//   - Reset: async reset_n.
// - Top contains the epoch counter, push mux, drop counter and wrap pulse.
// TESTING (CNT_W=4, EPOCH_W=12, DEPTH=4, DROP_W=8)
// 1 Reset: reset_n=0 mid-stream with 3 records queued
//   -> out_valid=0, drop_cnt=0, epoch=0 immediately (async);
//   no stale record after release.
// 2 Wraps with out_ready=1: ovf_in pulses with cnt_in=15, three times
//   -> out_data = {1,1,15}, {1,2,15}, {1,3,15} in order, 1 cycle after each push.
// 3 Overflow of FIFO: out_ready=0, 6 snap_req pulses at epoch=0 with cnt_in=0..5
//   -> fifo_full=1 after 4; drop_cnt=2.
//   Drain yields {0,0,0}..{0,0,3}.
// 4 Full + pop + push same cycle: FIFO full, out_ready=1, snap_req=1
//   -> no drop, fifo_full stays 1, head advances.
// 5 Simultaneous ovf_in+snap_req at epoch=7, cnt_in=15
//   -> exactly one record {1,8,15}.
// 6 Epoch rollover: preload 4095 wraps, next ovf_in -> record epoch=0,
//   epoch_wrap=1 for one cycle.
//   Then clear=1 with ovf_in=1 -> epoch=0, FIFO empty, no record.

Source files
------------

// File: rtl/ovf_log_pkg.sv
// rtl/ovf_log_pkg.sv - shared record kinds and layout helpers for the overflow epoch logger
package ovf_log_pkg;

    localparam logic KIND_SNAP = 1'b0;
    localparam logic KIND_OVF  = 1'b1;

    // Record layout, MSB first: {kind, epoch, count}
    function automatic int rec_w(input int epoch_w, input int cnt_w);
        return 1 + epoch_w + cnt_w;
    endfunction

    function automatic int kind_pos(input int epoch_w, input int cnt_w);
        return epoch_w + cnt_w;
    endfunction

    function automatic int epoch_lsb(input int cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/epoch_rec_fifo.sv
// rtl/epoch_rec_fifo.sv - register-array sync FIFO holding logger records
module epoch_rec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   occupancy
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign occupancy = wr_ptr - rd_ptr;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy == (AW+1)'(DEPTH));
    assign head      = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is only taken when the head leaves in the same cycle
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    // Pointer update; clear discards contents, reset does the same asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are meaningless outside the valid pointer window
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/overflow_epoch_logger.sv
// rtl/overflow_epoch_logger.sv - counts upstream wraps as epochs and logs wrap/snapshot records
module overflow_epoch_logger
    import ovf_log_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int EPOCH_W = 12,
    parameter int DEPTH   = 4,
    parameter int DROP_W  = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [CNT_W-1:0]                    cnt_in,
    input  logic                                ovf_in,
    input  logic                                snap_req,
    input  logic                                clear,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [rec_w(EPOCH_W, CNT_W)-1:0]    out_data,
    output logic                                fifo_full,
    output logic [DROP_W-1:0]                   drop_cnt,
    output logic                                epoch_wrap
);

    localparam int REC_W = rec_w(EPOCH_W, CNT_W);
    localparam int AW    = $clog2(DEPTH);

    logic [EPOCH_W-1:0] epoch;
    logic [EPOCH_W-1:0] rec_epoch;
    logic [REC_W-1:0]   rec;
    logic               push;
    logic               pop;
    logic               drop;
    logic               empty;
    logic               full;
    logic [AW:0]        occupancy;

    // An OVF record carries the post-increment epoch; a coincident snapshot is folded into it
    assign push      = ovf_in || snap_req;
    assign rec_epoch = ovf_in ? epoch + 1'b1 : epoch;
    assign rec       = {(ovf_in ? KIND_OVF : KIND_SNAP), rec_epoch, cnt_in};

    assign pop       = out_ready && !empty;
    assign drop      = push && full && !pop;
    assign out_valid = (occupancy != '0);
    assign fifo_full = full;

    epoch_rec_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .din       (rec),
        .head      (out_data),
        .empty     (empty),
        .full      (full),
        .occupancy (occupancy)
    );

    // Epoch counter advances on every wrap, whether or not its record fits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    epoch <= '0;
        else if (clear)  epoch <= '0;
        else if (ovf_in) epoch <= epoch + 1'b1;
    end

    // One-cycle pulse after the epoch rolls from all-ones back to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   epoch_wrap <= 1'b0;
        else if (clear) epoch_wrap <= 1'b0;
        else            epoch_wrap <= ovf_in && (&epoch);
    end

    // Saturating count of records lost to a full FIFO with no pop that cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      drop_cnt <= '0;
        else if (clear)                    drop_cnt <= '0;
        else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end

endmodule

// File: tb/tb_overflow_epoch_logger.sv
// tb/tb_overflow_epoch_logger.sv - scoreboard bench for overflow_epoch_logger
module tb_overflow_epoch_logger;

    localparam int DEPTH   = 4;
    localparam int EMAX    = 4096;
    localparam int DROPMAX = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  cnt_in;
    logic        ovf_in;
    logic        snap_req;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic        fifo_full;
    logic [7:0]  drop_cnt;
    logic        epoch_wrap;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];
    int          m_epoch = 0;
    int          m_drop  = 0;
    logic        m_wrap  = 1'b0;
    bit          mon_en  = 1'b0;

    overflow_epoch_logger dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cnt_in     (cnt_in),
        .ovf_in     (ovf_in),
        .snap_req   (snap_req),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_full  (fifo_full),
        .drop_cnt   (drop_cnt),
        .epoch_wrap (epoch_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk_rec(input bit kind, input int ep, input int cnt);
        logic [16:0] r;
        r = {kind, 12'(ep), 4'(cnt)};
        return r;
    endfunction

    // Monitor: compares DUT outputs against the model each cycle and retires accepted records
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            check("fifo_full", {31'b0, fifo_full}, {31'b0, exp_q.size() == DEPTH});
            check("drop_cnt", {24'b0, drop_cnt}, m_drop);
            check("epoch_wrap", {31'b0, epoch_wrap}, {31'b0, m_wrap});
            if (out_valid && exp_q.size() != 0) begin
                check("out_data", {15'b0, out_data}, {15'b0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Apply one cycle of stimulus and advance the reference model across the edge
    task automatic step(input bit ovf, input bit snap, input bit clr, input bit rdy, input int cnt);
        bit          push_now;
        bit          pop_now;
        bit          full_now;
        logic [16:0] r;
        ovf_in    = ovf;
        snap_req  = snap;
        clear     = clr;
        out_ready = rdy;
        cnt_in    = 4'(cnt);
        push_now  = !clr && (ovf || snap);
        pop_now   = rdy && (exp_q.size() != 0);
        full_now  = (exp_q.size() == DEPTH);
        r = ovf ? mk_rec(1'b1, (m_epoch + 1) % EMAX, cnt) : mk_rec(1'b0, m_epoch, cnt);
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
            m_epoch = 0;
            m_drop  = 0;
            m_wrap  = 1'b0;
        end else begin
            m_wrap = ovf && (m_epoch == EMAX - 1);
            if (ovf) m_epoch = (m_epoch + 1) % EMAX;
            if (push_now) begin
                if (!full_now || pop_now) exp_q.push_back(r);
                else if (m_drop < DROPMAX) m_drop++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ovf_in = 0; snap_req = 0; clear = 0; out_ready = 0; cnt_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_fifo_full", {31'b0, fifo_full}, 0);
        check("reset_drop_cnt", {24'b0, drop_cnt}, 0);
        check("reset_epoch_wrap", {31'b0, epoch_wrap}, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Wraps with consumer ready: {1,1,15},{1,2,15},{1,3,15}
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 15);
            step(0, 0, 0, 1, 0);
        end

        // Overfill with consumer stalled, then drain
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, i);
        step(0, 0, 0, 0, 0);
        check("ovfl_drop", {24'b0, drop_cnt}, 2);
        // Full + pop + push in the same cycle
        step(0, 1, 0, 1, 9);
        step(0, 1, 0, 1, 10);
        check("fullpop_full", {31'b0, fifo_full}, 1);
        check("fullpop_drop", {24'b0, drop_cnt}, 2);
        repeat (6) step(0, 0, 0, 1, 0);

        // Coincident wrap and snapshot at epoch 7
        step(0, 0, 1, 0, 0);
        repeat (7) step(1, 0, 0, 1, 3);
        step(1, 1, 0, 1, 15);
        repeat (3) step(0, 0, 0, 1, 0);

        // Drop counter saturation
        step(0, 0, 1, 0, 0);
        repeat (300) step(0, 1, 0, 0, 5);
        check("drop_sat", {24'b0, drop_cnt}, 255);
        repeat (5) step(0, 0, 0, 1, 0);

        // Async reset mid-stream with three records queued
        repeat (3) step(0, 1, 0, 0, 7);
        ovf_in = 0; snap_req = 0; out_ready = 0;
        @(negedge clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_out_valid", {31'b0, out_valid}, 0);
        check("async_drop_cnt", {24'b0, drop_cnt}, 0);
        exp_q.delete();
        m_epoch = 0; m_drop = 0; m_wrap = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step(0, 1, 0, 0, 2);
        repeat (2) step(0, 0, 0, 1, 0);

        // Epoch rollover, then clear overriding a wrap
        for (int i = 0; i < EMAX - 1; i++) step(1, 0, 0, 1, i % 16);
        repeat (2) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 4);
        check("roll_wrap", {31'b0, epoch_wrap}, 1);
        step(0, 0, 0, 1, 0);
        check("roll_wrap_end", {31'b0, epoch_wrap}, 0);
        step(1, 0, 0, 0, 6);
        step(1, 0, 1, 0, 6);
        check("clr_empty", {31'b0, out_valid}, 0);
        step(0, 1, 0, 1, 1);
        repeat (2) step(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15));
        end
        repeat (8) step(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
